// File: rtl/fsm_ser_pkg.sv
// Shared definitions for the serializer front end and the sibling sequence-detector benches.
package fsm_ser_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } ser_state_e;

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for piso_bit_serializer.
interface piso_bit_serializer_if #(
  parameter int WIDTH = fsm_ser_pkg::SER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             adv;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;

  modport master (
    output din, din_valid, adv,
    input  din_ready, ser_out, ser_valid, ser_first, ser_last
  );

  modport slave (
    input  din, din_valid, adv,
    output din_ready, ser_out, ser_valid, ser_first, ser_last
  );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry word buffer with a full flag; load and take are never asserted together.
module ser_hold_buf #(
  parameter int WIDTH = fsm_ser_pkg::SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             ready
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out front end, MSB first, gapless through a one-word hold buffer.
// Build with SER_PARITY_EN to append an even-parity bit after each word.
module piso_bit_serializer #(
  parameter int WIDTH = fsm_ser_pkg::SER_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  piso_bit_serializer_if.slave bus
);
  import fsm_ser_pkg::*;

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_bit_serializer: WIDTH must be >= 2");
  end

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full, hold_ready, hold_load, hold_take;
  logic             reload, is_last;
  logic             ser_out_c, ser_valid_c, ser_first_c, ser_last_c;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign hold_load     = bus.din_valid && hold_ready;
  assign bus.din_ready = hold_ready;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .take  (hold_take),
    .d     (bus.din),
    .q     (hold_q),
    .full  (hold_full),
    .ready (hold_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Every word boundary funnels into 'reload' so IDLE loads and gapless reloads share one path.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_take   = 1'b0;
    reload      = 1'b0;
    ser_out_c   = 1'b0;
    ser_valid_c = 1'b0;
    ser_first_c = 1'b0;
    ser_last_c  = 1'b0;
    is_last     = (cnt_q == LAST_CNT);
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: reload = hold_full;
      SHIFT: begin
        ser_out_c   = shreg_q[WIDTH-1];
        ser_valid_c = 1'b1;
        ser_first_c = (cnt_q == '0);
`ifdef SER_PARITY_EN
        ser_last_c  = 1'b0;
`else
        ser_last_c  = is_last;
`endif
        if (bus.adv) begin
          if (!is_last) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
`ifdef SER_PARITY_EN
          else begin
            state_d = PARITY;
          end
`else
          else if (hold_full) begin
            reload = 1'b1;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_out_c   = par_q;
        ser_valid_c = 1'b1;
        ser_last_c  = 1'b1;
        if (bus.adv) begin
          if (hold_full) begin
            reload = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (reload) begin
      hold_take = 1'b1;
      shreg_d   = hold_q;
      cnt_d     = '0;
      state_d   = SHIFT;
`ifdef SER_PARITY_EN
      par_d     = ^hold_q;
`endif
    end
  end

  assign bus.ser_out   = ser_out_c;
  assign bus.ser_valid = ser_valid_c;
  assign bus.ser_first = ser_first_c;
  assign bus.ser_last  = ser_last_c;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer: directed scenarios plus random traffic against a
// queue-of-symbols reference model. Define SER_PARITY_EN for both RTL and bench to cover parity.
module tb_piso_bit_serializer;
  import fsm_ser_pkg::*;

  localparam int W = SER_WIDTH_DEFAULT;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } sym_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sym_t             cur[$];
  logic             holdFull = 1'b0;
  logic [W-1:0]     holdWord = '0;

  piso_bit_serializer_if #(.WIDTH(W)) bus ();

  piso_bit_serializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expand a word into the symbols it should produce on the serial side.
  task automatic loadWord(input logic [W-1:0] w);
    sym_t s;
    for (int i = W - 1; i >= 0; i--) begin
      s.b     = w[i];
      s.first = (i == W - 1);
`ifdef SER_PARITY_EN
      s.last  = 1'b0;
`else
      s.last  = (i == 0);
`endif
      cur.push_back(s);
    end
`ifdef SER_PARITY_EN
    s.b = ^w; s.first = 1'b0; s.last = 1'b1;
    cur.push_back(s);
`endif
  endtask

  task automatic modelStep(input logic [W-1:0] d, input logic v, input logic a);
    logic acc;
    acc = v && !holdFull;
    if (cur.size() == 0) begin
      if (holdFull) begin
        loadWord(holdWord);
        holdFull = 1'b0;
      end
    end else if (a) begin
      void'(cur.pop_front());
      if (cur.size() == 0 && holdFull) begin
        loadWord(holdWord);
        holdFull = 1'b0;
      end
    end
    if (acc) begin
      holdFull = 1'b1;
      holdWord = d;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    sym_t s;
    s = '0;
    if (cur.size() > 0) s = cur[0];
    checkBit({tag, "_ser_out"},   bus.ser_out,   s.b);
    checkBit({tag, "_ser_valid"}, bus.ser_valid, cur.size() > 0);
    checkBit({tag, "_ser_first"}, bus.ser_first, s.first);
    checkBit({tag, "_ser_last"},  bus.ser_last,  s.last);
    checkBit({tag, "_din_ready"}, bus.din_ready, !holdFull);
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic a, input string tag);
    bus.din       = d;
    bus.din_valid = v;
    bus.adv       = a;
    modelStep(d, v, a);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [4:0]   win;
    logic         advSeq[12];
    logic [W-1:0] parPat[2];
    logic         parExp[2];
    logic [W-1:0] r;

    bus.din = '0; bus.din_valid = 1'b0; bus.adv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) applyStimulus('0, 1'b0, 1'b1, "idle");

    $display("[TB] single word DB");
    pat = 8'hDB;
    win = '0;
    applyStimulus(pat, 1'b1, 1'b1, "db_accept");
    for (int j = 1; j <= 11; j++) begin
      applyStimulus('0, 1'b0, 1'b1, "db_stream");
      if (j <= W) begin
        checkBit("db_const_bit", bus.ser_out, pat[W-j]);
        checkBit("db_const_first", bus.ser_first, j == 1);
`ifndef SER_PARITY_EN
        checkBit("db_const_last", bus.ser_last, j == W);
`endif
        win = {win[3:0], bus.ser_out};
        if (j >= 5) checkBit("db_det11011", win == 5'b11011, (j == 5) || (j == 8));
      end
    end

    $display("[TB] back-to-back DB then 1B");
    applyStimulus(8'hDB, 1'b1, 1'b1, "b2b_w0");
    applyStimulus(8'h1B, 1'b1, 1'b1, "b2b_blocked");
    applyStimulus(8'h1B, 1'b1, 1'b1, "b2b_w1");
    for (int j = 0; j < 22; j++) applyStimulus('0, 1'b0, 1'b1, "b2b_stream");

    $display("[TB] stalls on A5");
    advSeq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    applyStimulus(8'hA5, 1'b1, 1'b1, "stall_accept");
    foreach (advSeq[k]) applyStimulus('0, 1'b0, advSeq[k], "stall_stream");
    for (int j = 0; j < 4; j++) applyStimulus('0, 1'b0, 1'b1, "stall_drain");

    $display("[TB] async reset mid-word");
    applyStimulus(8'hF0, 1'b1, 1'b1, "rst_w0");
    applyStimulus(8'h0F, 1'b1, 1'b1, "rst_w1_blocked");
    applyStimulus(8'h0F, 1'b1, 1'b1, "rst_w1");
    applyStimulus('0, 1'b0, 1'b1, "rst_bit2");
    applyStimulus('0, 1'b0, 1'b1, "rst_bit3");
    #2;
    rst = 1'b0;
    cur.delete();
    holdFull = 1'b0;
    #1;
    checkOutput("rst_async");
    @(posedge clk);
    #1;
    checkOutput("rst_held");
    rst = 1'b1;
    for (int j = 0; j < 6; j++) applyStimulus('0, 1'b0, 1'b1, "rst_after");

`ifdef SER_PARITY_EN
    $display("[TB] parity words");
    parPat = '{8'h07, 8'h03};
    parExp = '{1'b1, 1'b0};
    for (int p = 0; p < 2; p++) begin
      applyStimulus(parPat[p], 1'b1, 1'b1, "par_accept");
      for (int j = 1; j <= 11; j++) begin
        applyStimulus('0, 1'b0, 1'b1, "par_stream");
        if (j == W) checkBit("par_data_last", bus.ser_last, 1'b0);
        if (j == W + 1) begin
          checkBit("par_bit", bus.ser_out, parExp[p]);
          checkBit("par_last", bus.ser_last, 1'b1);
        end
      end
    end
`else
    parPat = '{8'h07, 8'h03};
    parExp = '{1'b0, 1'b0};
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r = W'($urandom);
      applyStimulus(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), "rand");
    end
    for (int j = 0; j < 30; j++) applyStimulus('0, 1'b0, 1'b1, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
